line_buffer3: RTL

Producer side of the 3x3 Sobel window path. It accepts a raster-order 12-bit pixel stream, one pixel per accepted beat, and stores the two previous image rows in on-chip line memories. Each beat it emits one vertically aligned column of three pixels (`row0_pixel` oldest row, `row2_pixel` current row) with `valid` and `row2_pixel_edge`, ready to drive the convolution stage directly.

---
 rtl/line_buffer3_if.sv | 31 +++
 rtl/line_buffer3.sv | 135 +++++++++++++
 2 files changed

// File: rtl/line_buffer3_if.sv
// rtl/line_buffer3_if.sv - pixel stream input and three-row column output bundle
//
// Purpose: groups the raster pixel input and the column output of line_buffer3.
// Ports (signals):
//   pix_valid, pix_data, sof          : raster-order input beat, no backpressure
//   row0/1/2_pixel                    : column output, row0 oldest row
//   row2_pixel_edge, valid, eof       : column qualifiers
// Modports: master drives pixels and observes columns; slave is the line buffer.
interface line_buffer3_if #(
  parameter int DW = 12
);
  logic          pix_valid;
  logic [DW-1:0] pix_data;
  logic          sof;
  logic [DW-1:0] row0_pixel;
  logic [DW-1:0] row1_pixel;
  logic [DW-1:0] row2_pixel;
  logic          row2_pixel_edge;
  logic          valid;
  logic          eof;

  modport master (
    output pix_valid, pix_data, sof,
    input  row0_pixel, row1_pixel, row2_pixel, row2_pixel_edge, valid, eof
  );

  modport slave (
    input  pix_valid, pix_data, sof,
    output row0_pixel, row1_pixel, row2_pixel, row2_pixel_edge, valid, eof
  );
endinterface

// File: rtl/line_buffer3.sv
// rtl/line_buffer3.sv - two-line buffer emitting 3-row pixel columns for a 3x3 window
//
// Purpose: stores rows r-1 (line_a) and r-2 (line_b) of a raster stream and emits,
// one cycle after each accepted pixel, the vertical column (r-2, r-1, r) at that column.
// Ports:
//   clk  : clock
//   rst  : asynchronous active-low reset
//   bus  : line_buffer3_if.slave (pixel input, column output)
module line_buffer3 #(
  parameter int WIDTH  = 640,
  parameter int HEIGHT = 480,
  parameter int DW     = 12
) (
  input  logic           clk,
  input  logic           rst,
  line_buffer3_if.slave  bus
);
  localparam int CW = $clog2(WIDTH);
  localparam int RW = $clog2(HEIGHT);
  localparam logic [CW-1:0] COL_LAST = CW'(WIDTH - 1);
  localparam logic [RW-1:0] ROW_LAST = RW'(HEIGHT - 1);
  localparam logic [RW-1:0] ROW_TWO  = RW'(2);

  logic [DW-1:0] line_a [WIDTH];
  logic [DW-1:0] line_b [WIDTH];

  logic          beat;
  logic [CW-1:0] col_cur;
  logic [RW-1:0] row_cur;

  logic [CW-1:0] col_d, col_q;
  logic [RW-1:0] row_d, row_q;
  logic [DW-1:0] row2_d, row2_q;
  logic          edge_d, edge_q;
  logic          valid_d, valid_q;
  logic          eof_d, eof_q;
  logic          wb_pend_d, wb_pend_q;
  logic [CW-1:0] wb_addr_d, wb_addr_q;
  logic          byp_d, byp_q;
  logic [DW-1:0] byp_data_d, byp_data_q;

  // Block-RAM read registers; they double as the row1/row0 output registers,
  // so the synchronous read costs no extra latency.
  logic [DW-1:0] rd_a_q, rd_b_q;

  always_comb begin
    beat       = bus.pix_valid;
    // sof forces the current pixel to (0,0) whatever the counters say.
    col_cur    = bus.sof ? '0 : col_q;
    row_cur    = bus.sof ? '0 : row_q;
    col_d      = col_q;
    row_d      = row_q;
    row2_d     = row2_q;
    edge_d     = edge_q;
    valid_d    = 1'b0;
    eof_d      = 1'b0;
    wb_pend_d  = beat;
    wb_addr_d  = wb_addr_q;
    byp_d      = byp_q;
    byp_data_d = byp_data_q;
    if (beat) begin
      if (col_cur == COL_LAST) begin
        col_d = '0;
        row_d = (row_cur == ROW_LAST) ? '0 : row_cur + RW'(1);
      end else begin
        col_d = col_cur + CW'(1);
        row_d = row_cur;
      end
      row2_d    = bus.pix_data;
      edge_d    = (col_cur == '0) || (col_cur == COL_LAST);
      valid_d   = (row_cur >= ROW_TWO);
      eof_d     = (row_cur == ROW_LAST) && (col_cur == COL_LAST);
      wb_addr_d = col_cur;
      // The old line_a value only exists in rd_a_q one cycle after its beat, so the
      // line_b write trails by a cycle. If the next beat reads that same address in
      // the very cycle the write commits, the RAM returns stale data: forward it.
      byp_d      = wb_pend_q && (wb_addr_q == col_cur);
      byp_data_d = rd_a_q;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      col_q      <= '0;
      row_q      <= '0;
      row2_q     <= '0;
      edge_q     <= 1'b0;
      valid_q    <= 1'b0;
      eof_q      <= 1'b0;
      wb_pend_q  <= 1'b0;
      wb_addr_q  <= '0;
      byp_q      <= 1'b0;
      byp_data_q <= '0;
    end else begin
      col_q      <= col_d;
      row_q      <= row_d;
      row2_q     <= row2_d;
      edge_q     <= edge_d;
      valid_q    <= valid_d;
      eof_q      <= eof_d;
      wb_pend_q  <= wb_pend_d;
      wb_addr_q  <= wb_addr_d;
      byp_q      <= byp_d;
      byp_data_q <= byp_data_d;
    end
  end

  // Memory arrays: no reset, contents undefined until written.
  always_ff @(posedge clk) begin
    if (beat) begin
      line_a[col_cur] <= bus.pix_data;
    end
    if (wb_pend_q) begin
      line_b[wb_addr_q] <= rd_a_q;
    end
  end

  // Read-first: a read and write to the same line_a address return the old word.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rd_a_q <= '0;
      rd_b_q <= '0;
    end else if (beat) begin
      rd_a_q <= line_a[col_cur];
      rd_b_q <= line_b[col_cur];
    end
  end

  assign bus.row2_pixel      = row2_q;
  assign bus.row1_pixel      = rd_a_q;
  assign bus.row0_pixel      = byp_q ? byp_data_q : rd_b_q;
  assign bus.row2_pixel_edge = edge_q;
  assign bus.valid           = valid_q;
  assign bus.eof             = eof_q;
endmodule
